eth_xgpon_burst_framer: RTL

Store-and-forward framer between the 10G Ethernet RX datapath on GT x0y27 and the XG-PON burst-mode GT transmitter.
- Accepts AXI-Stream frames from the 10G MAC RX.
- Drops bad or overflowing frames.
- On each upstream grant, emits one burst: preamble, delimiter, header-prefixed whole frames, guard.
- Drives the burst GT TX data and burst enable directly, one 64-bit word per clock.

---
 rtl/xgpon_framer_pkg.sv | 39 +++
 rtl/framer_sync_fifo.sv | 67 ++++++
 rtl/eth_xgpon_burst_framer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xgpon_framer_pkg.sv
// Shared definitions for the Ethernet -> XG-PON burst framer.
//   - state_t          : egress FSM states
//   - HDR_*            : frame header field widths / bit offsets
//   - SCR_*            : scrambler polynomial taps (x^58 + x^39 + 1)
//   - payload_words()  : 64-bit words occupied by a byte length
//   - frame_cost()     : burst words consumed by one frame (header + payload)
package xgpon_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DELIM,
    ST_HDR,
    ST_PAY,
    ST_GUARD
  } state_t;

  // Header word layout: {magic, byte length, sequence number}
  localparam int HDR_MAGIC_W   = 16;
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_LEN_W     = 16;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_SEQ_W     = 32;
  localparam int HDR_SEQ_LSB   = 0;

  // Scrambler taps; state holds the last SCR_STATE_W scrambled bits
  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;
  localparam int SCR_STATE_W = 58;

  function automatic logic [16:0] payload_words(input logic [15:0] len);
    return ({1'b0, len} + 17'd7) >> 3;
  endfunction

  function automatic logic [16:0] frame_cost(input logic [15:0] len);
    return 17'd1 + payload_words(len);
  endfunction

endpackage

// File: rtl/framer_sync_fifo.sv
// Single-clock FIFO with speculative write support.
// Writes land at a speculative pointer; 'commit' publishes it (including a
// write on the same cycle), 'rewind' throws away everything since the last
// commit. Readers only ever see committed entries.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : speculative write
//   commit, rewind    : publish / discard the speculative entries
//   rd_en, rd_data    : pop; rd_data always shows the current head word
//   empty             : no committed entry visible to the reader
//   level             : speculative occupancy (written minus read)
module framer_sync_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic             rewind,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_cmt_ptr;
  logic [AW:0]      r_cmt_vis;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_inc;
  logic [AW:0]      w_rd_next;

  assign w_wr_inc  = r_wr_ptr + {{AW{1'b0}}, wr_en};
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, rd_en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_cmt_vis <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_wr_ptr <= rewind ? r_cmt_ptr : w_wr_inc;
      if (commit) r_cmt_ptr <= w_wr_inc;
      // The read register lags a write by one cycle, so a committed entry
      // is only exposed to the reader once rd_data can actually hold it.
      r_cmt_vis <= r_cmt_ptr;
      r_rd_ptr  <= w_rd_next;
    end
  end

  // Registered read of the post-pop head: rd_data tracks the head each cycle.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    r_rd_data <= r_mem[w_rd_next[AW-1:0]];
  end

  assign rd_data = r_rd_data;
  assign empty   = (r_rd_ptr == r_cmt_vis);
  assign level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/eth_xgpon_burst_framer.sv
// Store-and-forward framer: 10G MAC RX AXI-Stream in, XG-PON burst GT out.
// Good frames are queued whole; bad/overflowing frames are rewound and
// counted. Each grant emits preamble, delimiter, header+frame pairs that fit
// the word budget, then guard words, one 64-bit word per clock.
// Optional build macro: XGPON_SCRAMBLE_EN (x^58+x^39+1 scrambler on header and
// payload words, +1 cycle on gt_* and burst_done).
// Ports:
//   rx_core_clk / rx_core_reset  : clock, asynchronous active-high reset
//   s_axis_*                     : MAC RX stream (tready tied high)
//   burst_start, burst_len_words : grant pulse and its word budget
//   gt_txdata, gt_tx_burst_en    : burst GT transmit word and laser enable
//   burst_done                   : pulse as the FSM returns to idle
//   grant_overrun                : sticky, grant seen while busy
//   frames_sent, frames_dropped  : wrapping frame counters
//   fifo_level                   : data FIFO occupancy in words
module eth_xgpon_burst_framer
  import xgpon_framer_pkg::*;
#(
  parameter int          FIFO_DEPTH       = 512,
  parameter int          LEN_FIFO_DEPTH   = 32,
  parameter int          PREAMBLE_WORDS   = 4,
  parameter logic [63:0] PREAMBLE_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter logic [63:0] DELIMITER        = 64'hB598_3F4D_2ED6_C2A1,
  parameter int          GUARD_WORDS      = 2,
  parameter logic [15:0] HDR_MAGIC        = 16'hC0DE
) (
  input  logic        rx_core_clk,
  input  logic        rx_core_reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic        burst_start,
  input  logic [15:0] burst_len_words,
  output logic [63:0] gt_txdata,
  output logic        gt_tx_burst_en,
  output logic        burst_done,
  output logic        grant_overrun,
  output logic [31:0] frames_sent,
  output logic [31:0] frames_dropped,
  output logic [9:0]  fifo_level
);

  localparam int DAW = $clog2(FIFO_DEPTH);
  localparam int LAW = $clog2(LEN_FIFO_DEPTH);

  // Keep only the first 'rem' bytes of a final word (rem==0: whole word valid).
  function automatic logic [63:0] mask_tail(input logic [63:0] d, input logic [2:0] rem);
    logic [63:0] m;
    m = '1;
    if (rem != 3'd0) m = ~({64{1'b1}} << {rem, 3'b000});
    return d & m;
  endfunction

  // ---------------- ingress ----------------
  logic [15:0] r_wcnt;
  logic        r_ovf;
  logic [31:0] r_dropped;
  logic [DAW:0] w_data_level;
  logic [LAW:0] w_len_level;
  logic        w_data_full, w_len_full, w_data_empty, w_len_empty;
  logic        w_wr, w_last, w_commit, w_rewind;
  logic [15:0] w_len_in;
  logic [63:0] w_data_head;
  logic [15:0] w_len_head;
  logic        w_data_rd, w_len_rd;

  assign s_axis_tready = 1'b1;
  assign w_data_full = (w_data_level == (DAW+1)'(FIFO_DEPTH));
  assign w_len_full  = (w_len_level == (LAW+1)'(LEN_FIFO_DEPTH));
  assign w_wr     = s_axis_tvalid && !r_ovf && !w_data_full;
  assign w_last   = s_axis_tvalid && s_axis_tlast;
  assign w_commit = w_last && !s_axis_tuser && !r_ovf && !w_data_full && !w_len_full;
  assign w_rewind = w_last && !w_commit;
  // r_wcnt counts earlier beats, so this is 8*(words-1) + bytes in last beat
  assign w_len_in = 16'(r_wcnt << 3) + 16'($countones(s_axis_tkeep));

  always_ff @(posedge rx_core_clk or posedge rx_core_reset) begin
    if (rx_core_reset) begin
      r_wcnt    <= '0;
      r_ovf     <= 1'b0;
      r_dropped <= '0;
    end else begin
      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          r_wcnt <= '0;
          r_ovf  <= 1'b0;
        end else begin
          r_wcnt <= r_wcnt + 16'd1;
          if (w_data_full) r_ovf <= 1'b1;
        end
      end
      if (w_rewind) r_dropped <= r_dropped + 32'd1;
    end
  end

  framer_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk     (rx_core_clk),
    .rst     (rx_core_reset),
    .wr_en   (w_wr),
    .wr_data (s_axis_tdata),
    .commit  (w_commit),
    .rewind  (w_rewind),
    .rd_en   (w_data_rd),
    .rd_data (w_data_head),
    .empty   (w_data_empty),
    .level   (w_data_level)
  );

  framer_sync_fifo #(.WIDTH(16), .DEPTH(LEN_FIFO_DEPTH)) u_len_fifo (
    .clk     (rx_core_clk),
    .rst     (rx_core_reset),
    .wr_en   (w_commit),
    .wr_data (w_len_in),
    .commit  (w_commit),
    .rewind  (1'b0),
    .rd_en   (w_len_rd),
    .rd_data (w_len_head),
    .empty   (w_len_empty),
    .level   (w_len_level)
  );

  // ---------------- egress ----------------
  // r_state names the kind of word currently held in r_txd.
  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next, r_budget, w_budget_next, r_len, w_len_next;
  logic [31:0] r_seq, w_seq_next, r_sent, w_sent_next;
  logic [63:0] r_txd, w_txd_next, w_hdr;
  logic        r_en, w_en_next, r_done, w_done_next, r_overrun;
  logic        w_decide, w_can_start;
  logic [16:0] w_cost, w_cur_words;

  assign w_cost      = frame_cost(w_len_head);
  assign w_can_start = !w_len_empty && (w_cost <= {1'b0, r_budget});
  assign w_cur_words = payload_words(r_len);

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = HDR_MAGIC;
    w_hdr[HDR_LEN_LSB +: HDR_LEN_W]     = w_len_head;
    w_hdr[HDR_SEQ_LSB +: HDR_SEQ_W]     = r_seq;
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_budget_next = r_budget;
    w_len_next    = r_len;
    w_seq_next    = r_seq;
    w_sent_next   = r_sent;
    w_txd_next    = '0;
    w_en_next     = 1'b0;
    w_done_next   = 1'b0;
    w_data_rd     = 1'b0;
    w_len_rd      = 1'b0;
    w_decide      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (burst_start) begin
          w_state_next  = ST_PRE;
          w_budget_next = burst_len_words;
          w_cnt_next    = 16'd1;
          w_txd_next    = PREAMBLE_PATTERN;
          w_en_next     = 1'b1;
        end
      end
      ST_PRE: begin
        w_en_next = 1'b1;
        if (r_cnt >= 16'(PREAMBLE_WORDS)) begin
          w_state_next = ST_DELIM;
          w_txd_next   = DELIMITER;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
          w_txd_next = PREAMBLE_PATTERN;
        end
      end
      ST_DELIM: w_decide = 1'b1;
      ST_HDR: begin
        // r_cnt counts payload words still to follow the one loaded here
        w_en_next    = 1'b1;
        w_data_rd    = !w_data_empty;
        w_state_next = ST_PAY;
        w_cnt_next   = 16'(w_cur_words - 17'd1);
        if (w_cur_words == 17'd1) begin
          w_txd_next  = mask_tail(w_data_head, r_len[2:0]);
          w_sent_next = r_sent + 32'd1;
        end else begin
          w_txd_next = w_data_head;
        end
      end
      ST_PAY: begin
        if (r_cnt == 16'd0) begin
          w_decide = 1'b1;
        end else begin
          w_en_next  = 1'b1;
          w_data_rd  = !w_data_empty;
          w_cnt_next = r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            w_txd_next  = mask_tail(w_data_head, r_len[2:0]);
            w_sent_next = r_sent + 32'd1;
          end else begin
            w_txd_next = w_data_head;
          end
        end
      end
      ST_GUARD: begin
        if (r_cnt >= 16'(GUARD_WORDS)) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_en_next  = 1'b1;
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // After the delimiter or a frame's last word: next frame only if it fits whole.
    if (w_decide) begin
      w_en_next = 1'b1;
      if (w_can_start) begin
        w_state_next  = ST_HDR;
        w_txd_next    = w_hdr;
        w_seq_next    = r_seq + 32'd1;
        w_budget_next = r_budget - w_cost[15:0];
        w_len_next    = w_len_head;
        w_len_rd      = 1'b1;
      end else begin
        w_state_next = ST_GUARD;
        w_cnt_next   = 16'd1;
      end
    end
  end

  always_ff @(posedge rx_core_clk or posedge rx_core_reset) begin
    if (rx_core_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_budget  <= '0;
      r_len     <= '0;
      r_seq     <= '0;
      r_sent    <= '0;
      r_txd     <= '0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_budget <= w_budget_next;
      r_len    <= w_len_next;
      r_seq    <= w_seq_next;
      r_sent   <= w_sent_next;
      r_txd    <= w_txd_next;
      r_en     <= w_en_next;
      r_done   <= w_done_next;
      if (burst_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign grant_overrun  = r_overrun;
  assign frames_sent    = r_sent;
  assign frames_dropped = r_dropped;
  assign fifo_level     = 10'(w_data_level);

`ifdef XGPON_SCRAMBLE_EN
  logic [SCR_STATE_W-1:0] r_scr, w_scr_hist;
  logic [63:0]            w_scr_word, r_txd_q;
  logic                   r_en_q, r_done_q;

  // Bit 0 of each word goes first; each output bit feeds back into the history.
  always_comb begin
    w_scr_hist = r_scr;
    w_scr_word = '0;
    for (int i = 0; i < 64; i++) begin
      w_scr_word[i] = r_txd[i] ^ w_scr_hist[SCR_TAP_A-1] ^ w_scr_hist[SCR_TAP_B-1];
      w_scr_hist    = {w_scr_hist[SCR_STATE_W-2:0], w_scr_word[i]};
    end
  end

  always_ff @(posedge rx_core_clk or posedge rx_core_reset) begin
    if (rx_core_reset) begin
      r_scr    <= '1;
      r_txd_q  <= '0;
      r_en_q   <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_en_q   <= r_en;
      r_done_q <= r_done;
      if (r_state == ST_HDR || r_state == ST_PAY) begin
        r_scr   <= w_scr_hist;
        r_txd_q <= w_scr_word;
      end else begin
        if (r_state == ST_DELIM) r_scr <= '1;
        r_txd_q <= r_txd;
      end
    end
  end

  assign gt_txdata      = r_txd_q;
  assign gt_tx_burst_en = r_en_q;
  assign burst_done     = r_done_q;
`else
  assign gt_txdata      = r_txd;
  assign gt_tx_burst_en = r_en;
  assign burst_done     = r_done;
`endif

endmodule
